regfile_wb_ctrl: RTL

//  Write-side controller for the 3-port register file. Accepts writeback requests

---
 rtl/regfile_pkg.sv | 12 +
 rtl/wb_fifo.sv | 41 ++++
 rtl/regfile_wb_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request record used by the regfile write-side controller.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; extra pointer MSB separates full from empty on wrap.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t    mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_req;
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port arbiter for the register file: unbuffered ALU path A, FIFO-buffered path B,
// registered write strobe and a busy scoreboard of pending destinations. AW/DW must match the package.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DW         = REG_DW,
    parameter int AW         = REG_AW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_data,
    input  logic             alloc_valid,
    input  logic [AW-1:0]    alloc_addr,
    output logic             alloc_err,
    output logic [2**AW-1:0] busy,
    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [DW-1:0]    wd3
);

    localparam int NR = 2**AW;

    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    fifo_pop;
    wb_req_t fifo_head;
    wb_req_t b_req;
    logic    grant;
    wb_req_t grant_req;
    logic    alloc_hit;
    logic [NR-1:0] busy_nxt;

    assign b_req     = {b_addr, b_data};
    assign a_ready   = !reset && !fifo_full;
    assign b_ready   = !reset && !fifo_full;
    assign fifo_push = b_valid && b_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_req (b_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A full FIFO drains ahead of A so that a continuously busy ALU cannot starve path B.
    always_comb begin
        grant     = 1'b0;
        grant_req = '0;
        fifo_pop  = 1'b0;
        if (!reset) begin
            if (fifo_full && a_valid) begin
                grant     = 1'b1;
                grant_req = fifo_head;
                fifo_pop  = 1'b1;
            end else if (a_valid) begin
                grant     = 1'b1;
                grant_req = {a_addr, a_data};
            end else if (!fifo_empty) begin
                grant     = 1'b1;
                grant_req = fifo_head;
                fifo_pop  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= grant && (grant_req.addr != '0);
            if (grant) begin
                wa3 <= grant_req.addr;
                wd3 <= grant_req.data;
            end
        end
    end

    // Set beats clear when alloc and the committing write name the same register.
    always_comb begin
        busy_nxt = '0;
        for (int r = 1; r < NR; r++) begin
            busy_nxt[r] = (busy[r] && !(we3 && (wa3 == AW'(r))))
                        || (alloc_valid && (alloc_addr == AW'(r)));
        end
    end

    assign alloc_hit = alloc_valid && (alloc_addr != '0) && busy[alloc_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= '0;
            alloc_err <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            alloc_err <= alloc_hit;
        end
    end

endmodule
